// File: rtl/cfg_loader.sv
// cfg_loader: serial configuration loader for an array of 2-input LUT cells.
//
// A load begins with start in IDLE. After that, NBITS = 4*NCELLS data bits are
// taken LSB first through a valid/ready handshake (din/din_valid/din_ready)
// into a shadow register. When the last bit arrives, cfg is updated from the
// shadow register in a single step, and done pulses for one cycle.
//
// Optional feature (macro CFG_PARITY_EN): one even-parity bit follows the data
// bits. If the parity check fails, cfg is left unchanged, done does not pulse,
// and err is set. err stays set until the next accepted start or clr. Without
// the macro, err is tied to 0.
//
// Ports:
//   clk        in   clock; all state changes on its rising edge
//   clr        in   synchronous active-high reset
//   start      in   begin a load (ignored unless in IDLE)
//   din        in   serial configuration bit
//   din_valid  in   din carries a bit this cycle
//   din_ready  out  the block accepts din this cycle
//   cfg        out  cell k truth table at cfg[4k+3:4k] = {D11,D10,D01,D00}
//   busy       out  a load is in progress
//   done       out  one-cycle pulse when cfg has been updated
//   err        out  sticky parity-error flag
module cfg_loader #(
  parameter int unsigned NCELLS = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic                  din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [4*NCELLS-1:0]   cfg,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned NBITS = 4 * NCELLS;
  localparam int unsigned CNT_W = $clog2(NBITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef CFG_PARITY_EN
    PAR   = 2'd2,
`endif
    DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NBITS-1:0]   shadow_q, shadow_d;
  logic [NBITS-1:0]   cfg_q, cfg_d;
`ifdef CFG_PARITY_EN
  logic               par_q, par_d;
  logic               err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
`ifdef CFG_PARITY_EN
    par_d    = par_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SHIFT;
          cnt_d    = '0;
          shadow_d = '0;
`ifdef CFG_PARITY_EN
          par_d    = 1'b0;
          err_d    = 1'b0;
`endif
        end
      end
      SHIFT: begin
        if (din_valid) begin
          // Select the bit position by comparing against each index. This
          // avoids a variable index wider than the shadow register needs.
          for (int unsigned i = 0; i < NBITS; i++) begin
            if (cnt_q == CNT_W'(i)) shadow_d[i] = din;
          end
          cnt_d = cnt_q + CNT_W'(1);
`ifdef CFG_PARITY_EN
          par_d = par_q ^ din;
`endif
          if (cnt_q == CNT_W'(NBITS - 1)) begin
`ifdef CFG_PARITY_EN
            state_d = PAR;
`else
            // Load cfg on the same edge as the final bit, so DONE already
            // shows the complete word.
            state_d = DONE;
            cfg_d   = shadow_d;
`endif
          end
        end
      end
`ifdef CFG_PARITY_EN
      PAR: begin
        if (din_valid) begin
          if ((par_q ^ din) == 1'b0) begin
            state_d = DONE;
            cfg_d   = shadow_q;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      cfg_q    <= '0;
`ifdef CFG_PARITY_EN
      par_q    <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
`ifdef CFG_PARITY_EN
      par_q    <= par_d;
      err_q    <= err_d;
`endif
    end
  end

`ifdef CFG_PARITY_EN
  assign din_ready = (state_q == SHIFT) || (state_q == PAR);
  assign err       = err_q;
`else
  assign din_ready = (state_q == SHIFT);
  assign err       = 1'b0;
`endif
  assign busy = din_ready;
  assign done = (state_q == DONE);
  assign cfg  = cfg_q;

endmodule
